uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronised RXD, mid-bit sampling, LSB first.
// Good bytes leave as a one-cycle DATA_EN; a low stop bit gives one FRAME_ERR.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA_OUT,
    output logic       DATA_EN,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic [7:0]       shift, shift_nx;
    logic [7:0]       data_out_nx;
    logic             data_en_nx, frame_err_nx;
    logic             rxd_p0, rxd_p1;
    logic             rxs;

    // synchroniser stage: RXD -> rxd_p0 -> rxd_p1
    always_ff @(posedge CLK) begin
        if (RST) begin
            rxd_p0 <= 1'b1;
            rxd_p1 <= 1'b1;
        end else begin
            rxd_p0 <= RXD;
            rxd_p1 <= rxd_p0;
        end
    end

    assign rxs  = rxd_p1;
    assign BUSY = (state != S_IDLE);

    // frame state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            DATA_OUT  <= '0;
            DATA_EN   <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_idx   <= bit_idx_nx;
            shift     <= shift_nx;
            DATA_OUT  <= data_out_nx;
            DATA_EN   <= data_en_nx;
            FRAME_ERR <= frame_err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        bit_idx_nx   = bit_idx;
        shift_nx     = shift;
        data_out_nx  = DATA_OUT;
        data_en_nx   = 1'b0;
        frame_err_nx = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_nx = S_START;
                    cnt_nx   = '0;
                end
            end
            S_START: begin
                // half a bit in: still low means a real start bit, else a glitch
                if (cnt == HALF_M1) begin
                    cnt_nx = '0;
                    if (rxs) begin
                        state_nx = S_IDLE;
                    end else begin
                        state_nx   = S_DATA;
                        bit_idx_nx = '0;
                    end
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nx            = '0;
                    shift_nx[bit_idx] = rxs;
                    bit_idx_nx        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nx = S_STOP;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_nx = '0;
                    if (rxs) begin
                        data_out_nx = shift;
                        data_en_nx  = 1'b1;
                        state_nx    = S_IDLE;
                    end else begin
                        frame_err_nx = 1'b1;
                        state_nx     = S_BRK;
                    end
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_BRK: begin
                // a held-low line must return high before a new start is armed
                if (rxs) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: single frames, back-to-back
// stream, start glitch, line break and mid-frame reset.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       CLK;
    logic       RST;
    logic       RXD;
    logic [7:0] DATA_OUT;
    logic       DATA_EN;
    logic       FRAME_ERR;
    logic       BUSY;

    int n_chk  = 0;
    int n_fail = 0;

    int         cyc       = 0;
    int         en_cnt    = 0;
    int         fe_cnt    = 0;
    int         both_cnt  = 0;
    int         long_cnt  = 0;
    int         busy_cyc  = 0;
    int         en_time   = 0;
    logic       en_prev   = 1'b0;
    logic [7:0] rx_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RXD      (RXD),
        .DATA_OUT (DATA_OUT),
        .DATA_EN  (DATA_EN),
        .FRAME_ERR(FRAME_ERR),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // strobe monitor, sampled mid-cycle
    always @(negedge CLK) begin
        if (DATA_EN) begin
            rx_q.push_back(DATA_OUT);
            en_cnt  <= en_cnt + 1;
            en_time <= cyc;
        end
        if (FRAME_ERR) fe_cnt <= fe_cnt + 1;
        if (DATA_EN && FRAME_ERR) both_cnt <= both_cnt + 1;
        if (DATA_EN && en_prev) long_cnt <= long_cnt + 1;
        if (BUSY) busy_cyc <= busy_cyc + 1;
        en_prev <= DATA_EN;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b);
        RXD = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            idle(CPB);
        end
        RXD = 1'b1;
        idle(CPB);
    endtask

    logic [7:0] stream [6] = '{8'h52, 8'h20, 8'h33, 8'h46, 8'h0D, 8'h0A};

    initial begin
        int en0, fe0, q0, b0, t0, lat;
        logic [7:0] b3c;

        // 1: reset state and quiet idle line
        RST = 1'b1;
        RXD = 1'b1;
        idle(3);
        check("rst_data_out", DATA_OUT, 8'h00);
        check("rst_data_en", DATA_EN, 1'b0);
        check("rst_frame_err", FRAME_ERR, 1'b0);
        check("rst_busy", BUSY, 1'b0);
        RST = 1'b0;
        idle(100);
        check("idle_no_en", en_cnt, 0);
        check("idle_no_fe", fe_cnt, 0);

        // 2: single frame 0x57 with latency
        en0 = en_cnt;
        q0  = rx_q.size();
        t0  = cyc;
        send_byte(8'h57);
        idle(5);
        lat = en_time - (t0 + 1);
        check("f57_count", en_cnt - en0, 1);
        check("f57_data", (rx_q.size() > q0) ? rx_q[q0] : 8'hxx, 8'h57);
        check("f57_latency", (lat >= 153 && lat <= 155), 1'b1);
        check("f57_no_fe", fe_cnt, 0);
        check("f57_busy_low", BUSY, 1'b0);
        check("f57_data_out", DATA_OUT, 8'h57);

        // 3: back-to-back "R 3F\r\n"
        en0 = en_cnt;
        q0  = rx_q.size();
        for (int i = 0; i < 6; i++) send_byte(stream[i]);
        idle(10);
        check("b2b_count", en_cnt - en0, 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("b2b_byte%0d", i),
                  (rx_q.size() > q0 + i) ? rx_q[q0 + i] : 8'hxx, stream[i]);
        check("b2b_no_fe", fe_cnt, 0);
        check("b2b_single_cycle", long_cnt, 0);

        // 4: 4-cycle start glitch
        en0 = en_cnt;
        b0  = busy_cyc;
        RXD = 1'b0;
        idle(4);
        RXD = 1'b1;
        idle(40);
        check("glitch_no_en", en_cnt - en0, 0);
        check("glitch_no_fe", fe_cnt, 0);
        check("glitch_busy_short", (busy_cyc - b0 > 0) && (busy_cyc - b0 <= 10), 1'b1);
        check("glitch_busy_low", BUSY, 1'b0);

        // 5: 20-bit break, then 0x41
        en0 = en_cnt;
        fe0 = fe_cnt;
        RXD = 1'b0;
        idle(20 * CPB);
        RXD = 1'b1;
        idle(2 * CPB);
        check("brk_one_fe", fe_cnt - fe0, 1);
        check("brk_no_en", en_cnt - en0, 0);
        check("brk_data_held", DATA_OUT, 8'h0A);
        check("brk_busy_low", BUSY, 1'b0);
        q0 = rx_q.size();
        send_byte(8'h41);
        idle(5);
        check("brk_then_41_count", en_cnt - en0, 1);
        check("brk_then_41", (rx_q.size() > q0) ? rx_q[q0] : 8'hxx, 8'h41);
        check("brk_fe_total", fe_cnt - fe0, 1);

        // 6: reset during data bit 4 of 0x3C, then 0xA5
        en0 = en_cnt;
        b3c = 8'h3C;
        RXD = 1'b0;
        idle(CPB);
        for (int i = 0; i < 4; i++) begin
            RXD = b3c[i];
            idle(CPB);
        end
        RXD = b3c[4];
        idle(CPB / 2);
        RST = 1'b1;
        idle(1);
        check("abort_busy", BUSY, 1'b0);
        check("abort_data_out", DATA_OUT, 8'h00);
        RST = 1'b0;
        RXD = 1'b1;
        idle(12 * CPB);
        check("abort_no_en", en_cnt - en0, 0);
        q0 = rx_q.size();
        send_byte(8'hA5);
        idle(5);
        check("a5_count", en_cnt - en0, 1);
        check("a5_data", (rx_q.size() > q0) ? rx_q[q0] : 8'hxx, 8'hA5);
        check("a5_data_out", DATA_OUT, 8'hA5);

        check("never_en_and_fe", both_cnt, 0);
        check("en_always_single", long_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
